// File: rtl/pipe_cmd_pkg.sv
// rtl/pipe_cmd_pkg.sv - shared types and constants for the PIPE command sequencer
//
// Purpose: sequencer state encoding, request type, PIPE PowerDown codes and
//          the values PowerDown/Rate take out of reset.
// Ports:   none (package).

package pipe_cmd_pkg;

    typedef enum logic [2:0] {
        RST_WAIT     = 3'd0,
        IDLE         = 3'd1,
        PD_WAIT      = 3'd2,
        RATE_WAIT_OK = 3'd3,
        RATE_WAIT_ST = 3'd4
    } state_t;

    typedef enum logic {
        REQ_PD   = 1'b0,
        REQ_RATE = 1'b1
    } req_type_t;

    // PIPE PowerDown encodings
    localparam logic [3:0] P0  = 4'h0;
    localparam logic [3:0] P0s = 4'h1;
    localparam logic [3:0] P1  = 4'h2;
    localparam logic [3:0] P2  = 4'h3;

    localparam logic [3:0] PD_RESET   = P1;
    localparam logic [3:0] RATE_RESET = 4'h0;

endpackage

// File: rtl/pipe_cmd_sequencer_if.sv
// rtl/pipe_cmd_sequencer_if.sv - LTSSM request port plus PIPE command/status bus
//
// Purpose: bundles the request handshake, result pulses and the PIPE
//          PowerDown/Rate/PclkChange/PhyStatus signals.
// Modports:
//   master - the sequencer: drives req_ready, done, timeout, illegal,
//            phy_ready, PowerDown, Rate, PclkChangeAck.
//   slave  - the environment (LTSSM + PHY): drives req_valid, req_type,
//            req_value, PclkChangeOk, PhyStatus.

interface pipe_cmd_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_type;
    logic [3:0] req_value;
    logic       done;
    logic       timeout;
    logic       illegal;
    logic       phy_ready;
    logic [3:0] PowerDown;
    logic [3:0] Rate;
    logic       PclkChangeAck;
    logic       PclkChangeOk;
    logic       PhyStatus;

    modport master (
        input  req_valid, req_type, req_value, PclkChangeOk, PhyStatus,
        output req_ready, done, timeout, illegal, phy_ready,
               PowerDown, Rate, PclkChangeAck
    );

    modport slave (
        output req_valid, req_type, req_value, PclkChangeOk, PhyStatus,
        input  req_ready, done, timeout, illegal, phy_ready,
               PowerDown, Rate, PclkChangeAck
    );
endinterface

// File: rtl/pipe_cmd_timeout_cnt.sv
// rtl/pipe_cmd_timeout_cnt.sv - response timeout counter for the PIPE sequencer
//
// Purpose: counts cycles spent waiting for the PHY; saturates at
//          TIMEOUT_CYCLES-1 and flags expired while sitting there.
// Ports:
//   Clk     in  clock
//   Reset   in  asynchronous active-low reset
//   clear   in  restart the count at zero (request accepted)
//   enable  in  count this cycle (sequencer is waiting)
//   expired out count has reached TIMEOUT_CYCLES-1

module pipe_cmd_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Saturating keeps the budget spent: if the PCLK-change ack lands on the
    // expiry cycle, the following status wait expires on its first miss
    // instead of wrapping around for another full period.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);
endmodule

// File: rtl/pipe_cmd_sequencer.sv
// rtl/pipe_cmd_sequencer.sv - MAC-side PIPE PowerDown/Rate command sequencer
//
// Purpose: accepts one PowerDown or Rate request at a time from the LTSSM,
//          drives it onto the PIPE bus, waits for PhyStatus (and, for Rate,
//          the PCLK-change handshake), and reports done/timeout/illegal.
// Config:  PIPE_PCLK_CHANGE_HANDSHAKE_EN - when defined, Rate changes wait
//          for PclkChangeOk and answer with PclkChangeAck before waiting for
//          PhyStatus; otherwise PclkChangeAck stays 0 and PclkChangeOk is
//          ignored.
// Ports:
//   Clk    in  sole clock
//   Reset  in  asynchronous active-low reset
//   bus    pipe_cmd_sequencer_if.master (request port and PIPE signals)

module pipe_cmd_sequencer
    import pipe_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RATE       = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    pipe_cmd_sequencer_if.master        bus
);
    localparam logic [4:0] MAX_RATE_CODE = 5'(MAX_RATE);

    state_t     state, stateNext;
    logic [3:0] pdQ, pdNext;
    logic [3:0] rateQ, rateNext;
    logic       ackQ, ackNext;
    logic       doneQ, doneNext;
    logic       timeoutQ, timeoutNext;
    logic       illegalQ, illegalNext;
    logic       readyQ, readyNext;
    logic       phyReadyQ, phyReadyNext;
    logic       cntClear, cntEn, expired;

    pipe_cmd_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (cntClear),
        .enable (cntEn),
        .expired(expired)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= RST_WAIT;
            pdQ       <= PD_RESET;
            rateQ     <= RATE_RESET;
            ackQ      <= 1'b0;
            doneQ     <= 1'b0;
            timeoutQ  <= 1'b0;
            illegalQ  <= 1'b0;
            readyQ    <= 1'b0;
            phyReadyQ <= 1'b0;
        end else begin
            state     <= stateNext;
            pdQ       <= pdNext;
            rateQ     <= rateNext;
            ackQ      <= ackNext;
            doneQ     <= doneNext;
            timeoutQ  <= timeoutNext;
            illegalQ  <= illegalNext;
            readyQ    <= readyNext;
            phyReadyQ <= phyReadyNext;
        end
    end

    // readyQ mirrors "next state is IDLE", so it is high exactly while IDLE
    // and doubles as the accept qualifier.
    always_comb begin
        stateNext    = state;
        pdNext       = pdQ;
        rateNext     = rateQ;
        ackNext      = ackQ;
        doneNext     = 1'b0;
        timeoutNext  = 1'b0;
        illegalNext  = 1'b0;
        readyNext    = 1'b0;
        phyReadyNext = phyReadyQ;
        cntClear     = 1'b0;
        cntEn        = 1'b0;

        case (state)
            RST_WAIT: begin
                if (!bus.PhyStatus) begin
                    stateNext    = IDLE;
                    phyReadyNext = 1'b1;
                    readyNext    = 1'b1;
                end
            end

            IDLE: begin
                readyNext = 1'b1;
                if (bus.req_valid && readyQ) begin
                    cntClear = 1'b1;
                    if (bus.req_type == REQ_RATE) begin
                        if ({1'b0, bus.req_value} > MAX_RATE_CODE) begin
                            illegalNext = 1'b1;
                        end else if (bus.req_value == rateQ) begin
                            doneNext = 1'b1;
                        end else begin
                            rateNext  = bus.req_value;
                            readyNext = 1'b0;
`ifdef PIPE_PCLK_CHANGE_HANDSHAKE_EN
                            stateNext = RATE_WAIT_OK;
`else
                            stateNext = RATE_WAIT_ST;
`endif
                        end
                    end else begin
                        if (bus.req_value == pdQ) begin
                            doneNext = 1'b1;
                        end else begin
                            pdNext    = bus.req_value;
                            readyNext = 1'b0;
                            stateNext = PD_WAIT;
                        end
                    end
                end
            end

            // In every wait state the awaited event is tested before expiry,
            // so an event on the expiry cycle completes normally.
            PD_WAIT: begin
                cntEn = 1'b1;
                if (bus.PhyStatus) begin
                    doneNext  = 1'b1;
                    readyNext = 1'b1;
                    stateNext = IDLE;
                end else if (expired) begin
                    timeoutNext = 1'b1;
                    readyNext   = 1'b1;
                    stateNext   = IDLE;
                end
            end

            RATE_WAIT_OK: begin
`ifdef PIPE_PCLK_CHANGE_HANDSHAKE_EN
                cntEn = 1'b1;
                if (bus.PclkChangeOk) begin
                    ackNext   = 1'b1;
                    stateNext = RATE_WAIT_ST;
                end else if (expired) begin
                    ackNext     = 1'b0;
                    timeoutNext = 1'b1;
                    readyNext   = 1'b1;
                    stateNext   = IDLE;
                end
`else
                readyNext = 1'b1;
                stateNext = IDLE;
`endif
            end

            RATE_WAIT_ST: begin
                cntEn = 1'b1;
                if (bus.PhyStatus) begin
                    ackNext   = 1'b0;
                    doneNext  = 1'b1;
                    readyNext = 1'b1;
                    stateNext = IDLE;
                end else if (expired) begin
                    ackNext     = 1'b0;
                    timeoutNext = 1'b1;
                    readyNext   = 1'b1;
                    stateNext   = IDLE;
                end
            end

            default: begin
                stateNext = RST_WAIT;
            end
        endcase
    end

    assign bus.req_ready     = readyQ;
    assign bus.done          = doneQ;
    assign bus.timeout       = timeoutQ;
    assign bus.illegal       = illegalQ;
    assign bus.phy_ready     = phyReadyQ;
    assign bus.PowerDown     = pdQ;
    assign bus.Rate          = rateQ;
    assign bus.PclkChangeAck = ackQ;
endmodule

// File: tb/tb_pipe_cmd_sequencer.sv
// tb/tb_pipe_cmd_sequencer.sv - self-checking bench for pipe_cmd_sequencer

module tb_pipe_cmd_sequencer;
    localparam int T    = 16;
    localparam int MAXR = 4;
`ifdef PIPE_PCLK_CHANGE_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    pipe_cmd_sequencer_if bus();

    pipe_cmd_sequencer #(
        .TIMEOUT_CYCLES(T),
        .MAX_RATE      (MAXR)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int lastDoneCyc = -1;
    int lastToCyc = -1;
    int ackCycles = 0;
    int savedTo;
    bit checkEn = 1'b0;

    logic       expReady, expPhyReady, expDone, expTo, expIll, expAck;
    logic [3:0] expPd, expRate;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (checkEn) begin
            chk("req_ready", bus.req_ready, expReady);
            chk("phy_ready", bus.phy_ready, expPhyReady);
            chk("done", bus.done, expDone);
            chk("timeout", bus.timeout, expTo);
            chk("illegal", bus.illegal, expIll);
            chk("PowerDown", bus.PowerDown, expPd);
            chk("Rate", bus.Rate, expRate);
            chk("PclkChangeAck", bus.PclkChangeAck, expAck);
        end
    end

    always @(negedge Clk) begin
        if (bus.done === 1'b1) lastDoneCyc = cyc;
        if (bus.timeout === 1'b1) lastToCyc = cyc;
        if (bus.PclkChangeAck === 1'b1) ackCycles++;
    end

    task automatic step();
        @(posedge Clk);
        #1;
        expDone = 1'b0;
        expTo   = 1'b0;
        expIll  = 1'b0;
    endtask

    task automatic setResetExp();
        expPd = 4'h2; expRate = 4'h0; expAck = 1'b0; expReady = 1'b0;
        expPhyReady = 1'b0; expDone = 1'b0; expTo = 1'b0; expIll = 1'b0;
    endtask

    task automatic clearInputs();
        bus.req_valid = 1'b0; bus.PclkChangeOk = 1'b0; bus.PhyStatus = 1'b0;
    endtask

    task automatic doReset(input int phyHigh);
        clearInputs();
        Reset = 1'b0;
        bus.PhyStatus = 1'b1;
        setResetExp();
        step();
        step();
        Reset = 1'b1;
        repeat (phyHigh) step();
        bus.PhyStatus = 1'b0;
        step();
        expPhyReady = 1'b1;
        expReady = 1'b1;
    endtask

    task automatic abortSeq();
        chk("abort_ack_before", bus.PclkChangeAck, HS);
        clearInputs();
        Reset = 1'b0;
        #1;
        chk("abort_ack_async", bus.PclkChangeAck, 1'b0);
        chk("abort_rate_async", bus.Rate, 4'h0);
        chk("abort_pd_async", bus.PowerDown, 4'h2);
        chk("abort_ready_async", bus.req_ready, 1'b0);
        setResetExp();
        step();
        step();
        Reset = 1'b1;
        step();
        expPhyReady = 1'b1;
        expReady = 1'b1;
    endtask

    // Whole-transaction model: the timeout budget runs from the accept edge.
    // An awaited event sampled at edge k (counted from accept) wins when
    // k <= T; once the budget is gone the status wait gets one more chance,
    // so the status deadline is max(T, okEdge + 1).
    task automatic doRequest(input logic t, input logic [3:0] v, input int okD,
                             input int stD, input int abortAt);
        int a, compEdge, okEdge, phyEdge, tEdge;
        logic [3:0] cur;
        bit isDone;
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_value = v;
        step();
        acceptCyc = cyc;
        bus.req_valid = 1'b0;
        bus.req_value = 4'($urandom_range(0, 15));
        if (t && (v > MAXR)) begin
            expIll = 1'b1;
            return;
        end
        cur = t ? expRate : expPd;
        if (v == cur) begin
            expDone = 1'b1;
            return;
        end
        if (t) expRate = v; else expPd = v;
        expReady = 1'b0;
        a = (t && HS) ? okD : 0;
        okEdge = -1;
        phyEdge = -1;
        isDone = 1'b0;
        if (t && HS && okD > T) begin
            compEdge = T;
        end else begin
            if (t && HS) okEdge = okD;
            tEdge = (a + 1 > T) ? a + 1 : T;
            phyEdge = (stD == 0) ? -1 : a + stD;
            if (phyEdge > 0 && phyEdge <= tEdge) begin
                compEdge = phyEdge;
                isDone = 1'b1;
            end else begin
                compEdge = tEdge;
            end
        end
        for (int k = 1; k <= compEdge; k++) begin
            if (k == abortAt) begin
                abortSeq();
                return;
            end
            bus.PclkChangeOk = t && (k == okD);
            bus.PhyStatus    = (k == phyEdge);
            bus.req_valid    = (k == 2);
            if (k == 2) begin
                bus.req_type  = 1'($urandom_range(0, 1));
                bus.req_value = 4'($urandom_range(0, 15));
            end
            step();
            if (k == okEdge) expAck = 1'b1;
            if (k == compEdge) begin
                expAck = 1'b0;
                expReady = 1'b1;
                if (isDone) expDone = 1'b1; else expTo = 1'b1;
            end
        end
        clearInputs();
    endtask

    task automatic idleGap(input int n);
        repeat (n) begin
            bus.PhyStatus    = 1'($urandom_range(0, 1));
            bus.PclkChangeOk = 1'($urandom_range(0, 1));
            step();
        end
        clearInputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rt;
        logic [3:0] rv;
        clearInputs();
        bus.req_type = 1'b0;
        bus.req_value = 4'h0;
        Reset = 1'b0;
        setResetExp();
        step();
        checkEn = 1'b1;
        chk("rst_pd_lit", bus.PowerDown, 4'h2);
        chk("rst_rate_lit", bus.Rate, 4'h0);
        doReset(5);

        // PowerDown -> P0, PhyStatus 3 cycles after accept
        doRequest(1'b0, 4'h0, 0, 3, 0);
        step();
        chk("pd_done_latency", lastDoneCyc - acceptCyc, 3);
        chk("pd_value_lit", bus.PowerDown, 4'h0);

        // Rate -> 3, PclkChangeOk after 4, PhyStatus 6 later
        ackCycles = 0;
        doRequest(1'b1, 4'h3, 4, 6, 0);
        step();
        chk("ack_cycles", ackCycles, HS ? 6 : 0);
        chk("rate_done_latency", lastDoneCyc - acceptCyc, HS ? 10 : 6);
        chk("rate_value_lit", bus.Rate, 4'h3);

        // Illegal rate, then same-target PowerDown
        doRequest(1'b1, 4'h7, 1, 1, 0);
        step();
        chk("illegal_rate_kept", bus.Rate, 4'h3);
        doRequest(1'b0, 4'h2, 0, 1, 0);
        step();
        doRequest(1'b0, 4'h2, 0, 1, 0);
        step();
        chk("same_pd_latency", lastDoneCyc - acceptCyc, 0);

        // Timeout, and event exactly on the expiry cycle
        doRequest(1'b0, 4'h1, 0, 0, 0);
        step();
        chk("to_latency", lastToCyc - acceptCyc, T);
        chk("to_pd_kept", bus.PowerDown, 4'h1);
        savedTo = lastToCyc;
        doRequest(1'b0, 4'h3, 0, T, 0);
        step();
        chk("race_done_latency", lastDoneCyc - acceptCyc, T);
        chk("race_no_timeout", lastToCyc, savedTo);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rt = 1'($urandom_range(0, 1));
            rv = rt ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 3));
            doRequest(rt, rv, $urandom_range(1, 20),
                      ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20), 0);
            idleGap($urandom_range(0, 3));
        end

        // Reset while waiting for PhyStatus on a rate change
        doRequest(1'b1, (expRate == 4'h2) ? 4'h1 : 4'h2, 2, 0, 5);
        step();
        doRequest(1'b0, 4'h0, 0, 2, 0);
        idleGap(2);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_cmd_sequencer.md
# pipe_cmd_sequencer

MAC-side controller for the PIPE command/status interface: sequences PowerDown and Rate changes requested by the LTSSM, runs the PhyStatus handshake and the PCLK-change handshake, and flags PHYs that never respond. Sits between the LTSSM request port and the PowerDown/Rate/PclkChangeAck/PclkChangeOk/PhyStatus signals of the PIPE bus; exactly one request is in flight at a time.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles to wait for a PHY response before aborting; must be ≥ 2.
- `MAX_RATE`, default 4: highest legal Rate code (4 = Gen5).
- `Clk`  in  1  sole clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_type`  in  1  0 = PowerDown change, 1 = Rate change.
- `req_value`  in  4  target PowerDown or Rate code.
- `done`  out  1  one-cycle pulse: request completed.
- `timeout`  out  1  one-cycle pulse: PHY did not respond within TIMEOUT_CYCLES.
- `illegal`  out  1  one-cycle pulse: Rate request with `req_value` > MAX_RATE was rejected.
- `phy_ready`  out  1  PHY has left reset (PhyStatus seen low).
- `PowerDown`  out  4  PIPE PowerDown.
- `Rate`  out  4  PIPE Rate.
- `PclkChangeAck`  out  1  PIPE PCLK-change acknowledge.
- `PclkChangeOk`  in  1  PIPE PCLK-change ready from PHY.
- `PhyStatus`  in  1  PIPE PhyStatus.

## Operation
- Reset values: PowerDown = 4'h2 (P1), Rate = 0, PclkChangeAck = 0, req_ready = 0, done = timeout = illegal = 0, phy_ready = 0, state = RST_WAIT, counter = 0.
- States: RST_WAIT, IDLE, PD_WAIT, RATE_WAIT_OK, RATE_WAIT_ST.
- RST_WAIT: holds until PhyStatus is sampled low. On that cycle: IDLE, phy_ready = 1 (sticky until reset). No timeout in this state.
- IDLE: req_ready = 1. A request is accepted when req_valid && req_ready.
  - Rate with req_value > MAX_RATE: illegal pulse, outputs unchanged, stay IDLE.
  - Target equal to current PowerDown/Rate: done pulse, no PHY handshake, stay IDLE.
  - PowerDown change: PowerDown ← req_value, go to PD_WAIT.
  - Rate change: Rate ← req_value, go to RATE_WAIT_OK.
- PD_WAIT: PhyStatus high → done, IDLE.
- RATE_WAIT_OK: PclkChangeOk high → PclkChangeAck ← 1, RATE_WAIT_ST.
- RATE_WAIT_ST: PhyStatus high → PclkChangeAck ← 0, done, IDLE.
- Timeout counter: cleared on accept. Increments every cycle in PD_WAIT/RATE_WAIT_OK/RATE_WAIT_ST and is not cleared between the two rate substates. On reaching TIMEOUT_CYCLES−1 without the awaited event: timeout pulse, PclkChangeAck ← 0, IDLE. The new PowerDown/Rate value is retained.
- Simultaneous awaited event and timeout expiry: the event wins (done, no timeout).
- req_valid outside IDLE: ignored (req_ready = 0). The requester holds req_type/req_value stable while valid.
- Reset asserted mid-sequence: all registers return to their reset values immediately; no done/timeout pulse.

## Timing
- All outputs are registered.
- Accept at edge N → PowerDown/Rate show the new value after edge N; req_ready = 0 from edge N.
- PhyStatus sampled high at edge M → done = 1 for the cycle after M; req_ready = 1 in that same cycle.
- PclkChangeOk sampled high at edge K → PclkChangeAck = 1 after K. PhyStatus can complete no earlier than edge K+1.
- Minimum PowerDown round trip: 2 cycles from accept to ready.
- done, timeout and illegal are mutually exclusive.

## Configuration
- `PIPE_PCLK_CHANGE_HANDSHAKE_EN` defined: Rate change runs RATE_WAIT_OK → RATE_WAIT_ST with PclkChangeAck as described.
- Not defined: the accepted Rate request goes directly to RATE_WAIT_ST; PclkChangeAck is constant 0 and PclkChangeOk is ignored.

## Structure
- Package `pipe_cmd_pkg`:
  - state enum;
  - PowerDown codes P0 = 0, P0s = 1, P1 = 2, P2 = 3;
  - req_type enum (REQ_PD, REQ_RATE);
  - reset constants PD_RESET = P1, RATE_RESET = 0.
- Sub-module `pipe_cmd_timeout_cnt`: clear/enable counter of width $clog2(TIMEOUT_CYCLES) with an `expired` output.

## Test plan
- Reset release with PhyStatus high for 5 cycles, then low → phy_ready and req_ready rise the cycle after PhyStatus is sampled low; PowerDown = 2, Rate = 0 throughout.
- PowerDown request value 0; PhyStatus pulses 3 cycles after accept → PowerDown = 0 after accept, single done pulse, req_ready returns.
- Rate request value 3; PclkChangeOk after 4 cycles, PhyStatus 6 cycles later → Rate = 3, PclkChangeAck high only between those events, then done.
- Rate request value 7 with MAX_RATE = 4 → illegal pulse, Rate unchanged; PowerDown request value 2 while PowerDown = 2 → immediate done.
- TIMEOUT_CYCLES = 16, PowerDown request with no PhyStatus → timeout pulse exactly 16 cycles after accept, PowerDown keeps new value. Repeat with PhyStatus arriving on the expiry cycle → done, no timeout.
- Reset asserted in RATE_WAIT_ST → PclkChangeAck, Rate, PowerDown and req_ready return to reset values asynchronously; no done/timeout pulse.
